// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the ALU operand/result path and the response/status port
// around alu_arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_ctrl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_neg;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  ALUResult, resp_ready,
    output req0_ready, req1_ready,
    output ALUControl, SrcA, SrcB,
    output resp_valid, resp_id, resp_result, resp_zero, resp_neg, busy, op_count
  );

  // Requesters, ALU and response consumer side.
  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output ALUResult, resp_ready,
    input  req0_ready, req1_ready,
    input  ALUControl, SrcA, SrcB,
    input  resp_valid, resp_id, resp_result, resp_zero, resp_neg, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters; the result
// is captured with zero/negative flags and returned tagged with the owning requester id.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e           state_q;
  logic             rr_ptr_q;
  logic             owner_q;
  logic [1:0]       alu_ctrl_q;
  logic [WIDTH-1:0] src_a_q;
  logic [WIDTH-1:0] src_b_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic             resp_zero_q;
  logic             resp_neg_q;
  logic [CNT_W-1:0] op_count_q;

  logic any_valid;
  logic grant;

  // With a single valid requester it wins outright; rr_ptr only breaks ties.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid & bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
  end

  assign bus.req0_ready = (state_q == StIdle) & any_valid & ~grant;
  assign bus.req1_ready = (state_q == StIdle) & any_valid & grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      alu_ctrl_q    <= 2'b00;
      src_a_q       <= '0;
      src_b_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_neg_q    <= 1'b0;
      op_count_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            owner_q    <= grant;
            alu_ctrl_q <= grant ? bus.req1_ctrl : bus.req0_ctrl;
            src_a_q    <= grant ? bus.req1_a : bus.req0_a;
            src_b_q    <= grant ? bus.req1_b : bus.req0_b;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          resp_result_q <= bus.ALUResult;
          resp_zero_q   <= (bus.ALUResult == '0);
          resp_neg_q    <= bus.ALUResult[WIDTH-1];
          resp_valid_q  <= 1'b1;
          resp_id_q     <= owner_q;
          state_q       <= StDone;
        end
        StDone: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= ~owner_q;
            if (op_count_q != {CNT_W{1'b1}}) begin
              op_count_q <= op_count_q + 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ALUControl  = alu_ctrl_q;
  assign bus.SrcA        = src_a_q;
  assign bus.SrcB        = src_b_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_zero   = resp_zero_q;
  assign bus.resp_neg    = resp_neg_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model: one op
// outstanding, tie-break by last served requester, response two edges after acceptance.
module tb_alu_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned C = 16;

  logic clk;
  logic reset;

  alu_arbiter_if #(.WIDTH(W), .CNT_W(C)) bus ();

  alu_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_op(input logic [1:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stand-in for the external ALU.
  assign bus.ALUResult = alu_op(bus.ALUControl, bus.SrcA, bus.SrcB);

  int n_tests;
  int n_fail;

  // Model state.
  bit               m_pending;
  int               m_age;
  bit               m_id;
  bit               m_pref;
  logic [1:0]       m_ctrl;
  logic [W-1:0]     m_a;
  logic [W-1:0]     m_b;
  logic [W-1:0]     m_res;
  int               m_cnt;
  bit               done_ids[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_age     = 0;
    m_pref    = 0;
    m_cnt     = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".ALUControl"}, 64'(bus.ALUControl), 64'd0);
    check_eq({tag, ".SrcA"}, 64'(bus.SrcA), 64'd0);
    check_eq({tag, ".SrcB"}, 64'(bus.SrcB), 64'd0);
    check_eq({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check_eq({tag, ".resp_id"}, 64'(bus.resp_id), 64'd0);
    check_eq({tag, ".resp_result"}, 64'(bus.resp_result), 64'd0);
    check_eq({tag, ".resp_zero"}, 64'(bus.resp_zero), 64'd0);
    check_eq({tag, ".resp_neg"}, 64'(bus.resp_neg), 64'd0);
    check_eq({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, ".op_count"}, 64'(bus.op_count), 64'd0);
  endtask

  // One clock cycle: drive at the falling edge, check, predict the next rising edge.
  task automatic step(input bit v0, input logic [1:0] c0, input logic [W-1:0] a0,
                      input logic [W-1:0] b0, input bit v1, input logic [1:0] c1,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rr);
    bit g;
    bit idle;
    bit rv;
    bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
    bus.resp_ready = rr;
    #1;
    g    = (v0 && v1) ? m_pref : v1;
    idle = !m_pending;
    rv   = m_pending && (m_age >= 2);
    check_eq("req0_ready", 64'(bus.req0_ready), 64'(idle && v0 && !g));
    check_eq("req1_ready", 64'(bus.req1_ready), 64'(idle && v1 && g));
    check_eq("busy", 64'(bus.busy), 64'(m_pending));
    check_eq("op_count", 64'(bus.op_count), 64'(m_cnt));
    check_eq("resp_valid", 64'(bus.resp_valid), 64'(rv));
    if (m_pending) begin
      check_eq("ALUControl", 64'(bus.ALUControl), 64'(m_ctrl));
      check_eq("SrcA", 64'(bus.SrcA), 64'(m_a));
      check_eq("SrcB", 64'(bus.SrcB), 64'(m_b));
    end
    if (rv) begin
      check_eq("resp_id", 64'(bus.resp_id), 64'(m_id));
      check_eq("resp_result", 64'(bus.resp_result), 64'(m_res));
      check_eq("resp_zero", 64'(bus.resp_zero), 64'(m_res == '0));
      check_eq("resp_neg", 64'(bus.resp_neg), 64'(m_res[W-1]));
    end
    if (idle && (v0 || v1)) begin
      m_pending = 1;
      m_age     = 1;
      m_id      = g;
      m_ctrl    = g ? c1 : c0;
      m_a       = g ? a1 : a0;
      m_b       = g ? b1 : b0;
      m_res     = alu_op(m_ctrl, m_a, m_b);
    end else if (rv && rr) begin
      m_pending = 0;
      m_pref    = !m_id;
      if (m_cnt < (1 << C) - 1) m_cnt++;
      done_ids.push_back(m_id);
    end else if (m_pending) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic idle_step(input bit rr);
    step(0, 2'b00, '0, '0, 0, 2'b00, '0, '0, rr);
  endtask

  task automatic apply_reset();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.resp_ready = 0;
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [W-1:0] rand_opnd();
    return (($urandom % 4) == 0) ? W'($urandom % 3) : W'($urandom);
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req0_valid = 0; bus.req0_ctrl = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_ctrl = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.resp_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;
    @(negedge clk);

    // T1: lone ADD 1+0 from req0.
    step(1, 2'b00, 32'd1, 32'd0, 0, 2'b00, '0, '0, 0);
    step(0, 2'b00, '0, '0, 0, 2'b00, '0, '0, 0);
    check_eq("t1_result", 64'(bus.resp_result), 64'd1);
    idle_step(1);

    // T2: both valid from reset, req0 wins first.
    apply_reset();
    done_ids.delete();
    for (int i = 0; i < 6; i++) step(1, 2'b01, 32'd1, 32'd1, 1, 2'b11, 32'd0, 32'd1, 1);
    check_eq("t2_n", 64'(done_ids.size()), 64'd2);
    if (done_ids.size() == 2) begin
      check_eq("t2_id0", 64'(done_ids[0]), 64'd0);
      check_eq("t2_id1", 64'(done_ids[1]), 64'd1);
    end

    // T3: hold response for 5 cycles in DONE with both requesters pushing.
    step(1, 2'b10, 32'hFF, 32'h3C, 1, 2'b00, 32'd7, 32'd9, 0);
    step(1, 2'b10, 32'hFF, 32'h3C, 1, 2'b00, 32'd7, 32'd9, 0);
    for (int i = 0; i < 5; i++) step(1, 2'b01, 32'd5, 32'd5, 1, 2'b01, 32'd6, 32'd6, 0);
    check_eq("t3_count_held", 64'(bus.op_count), 64'd2);
    step(0, 2'b00, '0, '0, 0, 2'b00, '0, '0, 1);
    check_eq("t3_count_done", 64'(bus.op_count), 64'd3);

    // T4: strict alternation over 6 operations.
    apply_reset();
    done_ids.delete();
    for (int i = 0; i < 18; i++) step(1, 2'b00, 32'(i), 32'd1, 1, 2'b11, 32'(i), 32'd2, 1);
    check_eq("t4_count", 64'(bus.op_count), 64'd6);
    check_eq("t4_n", 64'(done_ids.size()), 64'd6);
    foreach (done_ids[k]) check_eq("t4_id", 64'(done_ids[k]), 64'(k % 2));

    // T5: wrap and zero flag.
    step(0, 2'b00, '0, '0, 1, 2'b01, 32'd0, 32'd1, 1);
    idle_step(1);
    check_eq("t5_sub", 64'(bus.resp_result), 64'hFFFF_FFFF);
    check_eq("t5_neg", 64'(bus.resp_neg), 64'd1);
    idle_step(1);
    step(1, 2'b10, 32'hF0, 32'h0F, 0, 2'b00, '0, '0, 1);
    idle_step(1);
    check_eq("t5_and_zero", 64'(bus.resp_zero), 64'd1);
    idle_step(1);

    // T6: reset while in ISSUE, then req0 must win the first tie.
    step(0, 2'b00, '0, '0, 1, 2'b11, 32'h55, 32'hAA, 0);
    bus.req1_valid = 0;
    reset = 1'b1;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    check_all_zero("t6_held");
    reset = 1'b0;
    model_reset();
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    #1;
    check_eq("t6_grant0", 64'(bus.req0_ready), 64'd1);
    @(negedge clk);
    model_reset();
    apply_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 6, 2'($urandom), rand_opnd(), rand_opnd(),
           ($urandom % 10) < 6, 2'($urandom), rand_opnd(), rand_opnd(),
           ($urandom % 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
